// File: rtl/minmax_pkg.sv
// Shared constants for the min/max packet statistics stage.
// Holds the FSM state encoding and the default widths.
package minmax_pkg;

    localparam int DEF_W     = 3;
    localparam int DEF_CNT_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCUM  = 2'd1;
    localparam state_t ST_REPORT = 2'd2;

endpackage

// File: rtl/mag_cmp.sv
// Unsigned magnitude comparator slice: exactly one of gt/eq/lt is high.
module mag_cmp #(
    parameter int W = 3
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         eq,
    output logic         lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/minmax_tracker.sv
// Packet statistics stage: tracks min, max, saturating count and all-equal
// over a valid/ready input stream and hands one summary per packet downstream.
module minmax_tracker
    import minmax_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_min,
    output logic [W-1:0]     out_max,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             out_all_eq
);

    state_t           state_q, state_d;
    logic [W-1:0]     min_q, min_d;
    logic [W-1:0]     max_q, max_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic max_gt, max_eq, max_lt;
    logic min_gt, min_eq, min_lt;
    logic mm_gt, mm_eq, mm_lt;
    logic in_fire, out_fire;
    logic unused_cmp;

    mag_cmp #(.W(W)) u_cmp_max (.a(in_data), .b(max_q), .gt(max_gt), .eq(max_eq), .lt(max_lt));
    mag_cmp #(.W(W)) u_cmp_min (.a(in_data), .b(min_q), .gt(min_gt), .eq(min_eq), .lt(min_lt));
    mag_cmp #(.W(W)) u_cmp_mm  (.a(min_q),   .b(max_q), .gt(mm_gt),  .eq(mm_eq),  .lt(mm_lt));

    // Only one decision per slice is needed; the rest are tied off here.
    assign unused_cmp = ^{max_eq, max_lt, min_gt, min_eq, mm_gt, mm_lt};

    assign in_ready  = (state_q != ST_REPORT);
    assign out_valid = (state_q == ST_REPORT);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign out_min    = min_q;
    assign out_max    = max_q;
    assign out_count  = cnt_q;
    assign out_ovf    = ovf_q;
    assign out_all_eq = mm_eq & out_valid;

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    min_d   = in_data;
                    max_d   = in_data;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = in_last ? ST_REPORT : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_fire) begin
                    // Ties never move the extremes.
                    if (max_gt) max_d = in_data;
                    if (min_lt) min_d = in_data;
                    if (&cnt_q) ovf_d = 1'b1;
                    else        cnt_d = cnt_q + CNT_W'(1);
                    if (in_last) state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (out_fire) begin
                    state_d = ST_IDLE;
                    min_d   = '0;
                    max_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            min_q   <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
